// File: rtl/dht11_sensor_model.sv
// DHT11 responder: the sensor end of the single-wire DHT11 protocol.
// Qualifies a host start pulse on dhtio, then drives the response sequence (sync low/high)
// and a 40-bit frame {hum_int, hum_dec, tmp_int, tmp_dec, checksum}, MSB first.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   hum_int    humidity integral byte      hum_dec  humidity decimal byte
//   tmp_int    temperature integral byte   tmp_dec  temperature decimal byte
//   inject_err inverts checksum bit 0 when sampled at frame latch
//   busy       high from start qualification until the line is released
//   frame_done one-cycle pulse when the trailing stop low ends
//   debug      current FSM state code
//   dhtio      shared open line; driven only during the response window
module dht11_sensor_model #(
  parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30,
  parameter int unsigned SYNC_L_US     = 80,
  parameter int unsigned SYNC_H_US     = 80,
  parameter int unsigned BIT_L_US      = 50,
  parameter int unsigned BIT0_H_US     = 28,
  parameter int unsigned BIT1_H_US     = 70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tmp_int,
  input  logic [7:0] tmp_dec,
  input  logic       inject_err,
  output logic       busy,
  output logic       frame_done,
  output logic [3:0] debug,
  inout  wire        dhtio
);

  localparam int unsigned TickDiv = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int unsigned PreW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned CntW    = 20;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StStartLow = 4'd1,
    StWaitRel  = 4'd2,
    StRespDly  = 4'd3,
    StSyncL    = 4'd4,
    StSyncH    = 4'd5,
    StBitL     = 4'd6,
    StBitH     = 4'd7,
    StStopL    = 4'd8
  } state_e;

  state_e          state_q, state_d;
  logic [PreW-1:0] presc_q;
  logic [CntW-1:0] cnt_q;
  logic            sync1_q, sync2_q;
  logic            armed_q;
  logic [39:0]     shift_q;
  logic [5:0]      bit_idx_q;
  logic            drv_en_q, drv_val_q, busy_q, frame_done_q;

  logic            line_s;
  logic            us_tick;
  logic            phase_end;
  logic            entering;
  logic [CntW-1:0] phase_len;
  logic [7:0]      cks;

  assign dhtio      = drv_en_q ? drv_val_q : 1'bz;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign debug      = state_q;

  assign line_s   = sync2_q;
  assign us_tick  = (presc_q == PreW'(TickDiv - 1));
  assign entering = (state_d != state_q);
  // 8-bit sum wraps mod 256 by width.
  assign cks      = (hum_int + hum_dec + tmp_int + tmp_dec) ^ {7'd0, inject_err};

  // Length in us of the phase timed by the current state.
  always_comb begin
    phase_len = CntW'(1);
    case (state_q)
      StStartLow: phase_len = CntW'(START_MIN_US);
      StRespDly:  phase_len = CntW'(RESP_DELAY_US);
      StSyncL:    phase_len = CntW'(SYNC_L_US);
      StSyncH:    phase_len = CntW'(SYNC_H_US);
      StBitL:     phase_len = CntW'(BIT_L_US);
      StBitH:     phase_len = shift_q[39] ? CntW'(BIT1_H_US) : CntW'(BIT0_H_US);
      StStopL:    phase_len = CntW'(BIT_L_US);
      default:    phase_len = CntW'(1);
    endcase
  end

  // Phase ends on its Nth tick; counters restart on every state entry.
  assign phase_end = us_tick && (cnt_q == phase_len - CntW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (armed_q && !line_s) state_d = StStartLow;
      StStartLow: begin
        if (line_s)         state_d = StIdle;
        else if (phase_end) state_d = StWaitRel;
      end
      StWaitRel:  if (line_s) state_d = StRespDly;
      StRespDly:  if (phase_end) state_d = StSyncL;
      StSyncL:    if (phase_end) state_d = StSyncH;
      StSyncH:    if (phase_end) state_d = StBitL;
      StBitL:     if (phase_end) state_d = StBitH;
      StBitH:     if (phase_end) state_d = (bit_idx_q == 6'd0) ? StStopL : StBitL;
      StStopL:    if (phase_end) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      cnt_q        <= '0;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      armed_q      <= 1'b0;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      drv_en_q     <= 1'b0;
      drv_val_q    <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sync1_q <= dhtio;
      sync2_q <= sync1_q;
      state_q <= state_d;

      if (entering || us_tick) presc_q <= '0;
      else                     presc_q <= presc_q + PreW'(1);

      if (entering)     cnt_q <= '0;
      else if (us_tick) cnt_q <= cnt_q + CntW'(1);

      // The line may still read low right after our stop low; arm only after a high sample.
      armed_q <= (state_q == StIdle) && (state_d == StIdle) && (armed_q || line_s);

      if (state_q == StWaitRel && state_d == StRespDly) begin
        shift_q <= {hum_int, hum_dec, tmp_int, tmp_dec, cks};
      end else if (state_q == StBitH && state_d == StBitL) begin
        shift_q <= {shift_q[38:0], 1'b0};
      end

      if (state_q == StSyncH && state_d == StBitL) begin
        bit_idx_q <= 6'd39;
      end else if (state_q == StBitH && state_d == StBitL) begin
        bit_idx_q <= bit_idx_q - 6'd1;
      end

      drv_en_q     <= (state_d >= StSyncL) && (state_d <= StStopL);
      drv_val_q    <= !(state_d == StSyncL || state_d == StBitL || state_d == StStopL);
      busy_q       <= (state_d >= StWaitRel) && (state_d <= StStopL);
      frame_done_q <= (state_q == StStopL) && (state_d == StIdle);
    end
  end

endmodule
